// File: rtl/gpia2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpia2_pkg
// Brief    : Register map constants for the gpia2 parallel-port adapter.
// Revision : 1.0  initial release
// ============================================================================
package gpia2_pkg;

    typedef logic [2:0] gpia2_adr_t;

    localparam gpia2_adr_t GPIA2_A_IN     = 3'd0;
    localparam gpia2_adr_t GPIA2_A_OUT    = 3'd1;
    localparam gpia2_adr_t GPIA2_A_SET    = 3'd2;
    localparam gpia2_adr_t GPIA2_A_CLR    = 3'd3;
    localparam gpia2_adr_t GPIA2_A_TGL    = 3'd4;
    localparam gpia2_adr_t GPIA2_A_DIR    = 3'd5;
    localparam gpia2_adr_t GPIA2_A_EDGE   = 3'd6;
    localparam gpia2_adr_t GPIA2_A_IRQEN  = 3'd7;

    localparam int GPIA2_NUM_REGS = 8;

endpackage
`default_nettype wire

// File: rtl/gpia2_sync.sv
`default_nettype none
// ============================================================================
// Module   : gpia2_sync
// Brief    : Pin synchroniser, previous-value flop and post-reset arm counter;
//            produces the synchronised input vector and the edge-event vector.
//            GPIA2_ANY_EDGE_EN selects both-edge events instead of rising only.
// Revision : 1.0  initial release
// ============================================================================
module gpia2_sync
    import gpia2_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_in,
    output logic [WIDTH-1:0] o_event
);

    localparam int                c_CNT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_CNT_W-1:0] c_ARM_DONE = c_CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [c_CNT_W-1:0]                r_arm_cnt;
    logic [WIDTH-1:0]                  w_in;
    logic [WIDTH-1:0]                  w_change;
    logic                              w_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= '0;
            r_prev    <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pins};
            r_prev <= w_in;
            if (!w_armed)
                r_arm_cnt <= r_arm_cnt + c_CNT_W'(1);
        end
    end

    assign w_in    = r_sync[SYNC_STAGES-1];
    // Until the chain and prev flop have both filled, IN vs prev is meaningless.
    assign w_armed = (r_arm_cnt == c_ARM_DONE);

`ifdef GPIA2_ANY_EDGE_EN
    assign w_change = w_in ^ r_prev;
`else
    assign w_change = w_in & ~r_prev;
`endif

    assign o_in    = w_in;
    assign o_event = w_armed ? w_change : '0;

endmodule
`default_nettype wire

// File: rtl/gpia2.sv
`default_nettype none
// ============================================================================
// Module   : gpia2
// Brief    : Wishbone B3 slave with a WIDTH-bit parallel port: direction
//            control, set/clear/toggle writes, edge-latched interrupts.
//            Optional macro GPIA2_ANY_EDGE_EN latches both pin edges.
// Revision : 1.0  initial release
// ============================================================================
module gpia2
    import gpia2_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [2:0]       ADR_I,
    input  logic             WE_I,
    input  logic             CYC_I,
    input  logic             STB_I,
    input  logic [WIDTH-1:0] DAT_I,
    output logic [WIDTH-1:0] DAT_O,
    output logic             ACK_O,
    input  logic [WIDTH-1:0] PORT_I,
    output logic [WIDTH-1:0] PORT_O,
    output logic [WIDTH-1:0] PORT_OE_O,
    output logic             INT_O
);

    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_irqen;
    logic [WIDTH-1:0] r_dat;
    logic             r_ack;
    logic             r_int;

    logic [WIDTH-1:0] w_in;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_rdata;
    logic             w_accept;
    logic             w_wr;

    gpia2_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLK_I),
        .rst     (RST_I),
        .i_pins  (PORT_I),
        .o_in    (w_in),
        .o_event (w_event)
    );

    // A transfer is taken only in the cycle before ACK rises: one wait state.
    assign w_accept = CYC_I & STB_I & ~r_ack;
    assign w_wr     = w_accept & WE_I;
    assign w_w1c    = (w_wr && (ADR_I == GPIA2_A_EDGE)) ? DAT_I : '0;

    always_comb begin
        w_rdata = '0;
        case (ADR_I)
            GPIA2_A_IN:    w_rdata = w_in;
            GPIA2_A_OUT,
            GPIA2_A_SET,
            GPIA2_A_CLR,
            GPIA2_A_TGL:   w_rdata = r_out;
            GPIA2_A_DIR:   w_rdata = r_dir;
            GPIA2_A_EDGE:  w_rdata = r_edge;
            GPIA2_A_IRQEN: w_rdata = r_irqen;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_out   <= '0;
            r_dir   <= '0;
            r_edge  <= '0;
            r_irqen <= '0;
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            r_ack <= CYC_I & STB_I & ~r_ack;
            if (w_accept)
                r_dat <= w_rdata;
            if (w_wr) begin
                case (ADR_I)
                    GPIA2_A_OUT:   r_out   <= DAT_I;
                    GPIA2_A_SET:   r_out   <= r_out | DAT_I;
                    GPIA2_A_CLR:   r_out   <= r_out & ~DAT_I;
                    GPIA2_A_TGL:   r_out   <= r_out ^ DAT_I;
                    GPIA2_A_DIR:   r_dir   <= DAT_I;
                    GPIA2_A_IRQEN: r_irqen <= DAT_I;
                    default:       ;
                endcase
            end
            // New events override a simultaneous clear so no edge is lost.
            r_edge <= (r_edge & ~w_w1c) | w_event;
            r_int  <= |(r_edge & r_irqen);
        end
    end

    assign DAT_O     = r_dat;
    assign ACK_O     = r_ack;
    assign PORT_O    = r_out;
    assign PORT_OE_O = r_dir;
    assign INT_O     = r_int;

endmodule
`default_nettype wire

// File: tb/tb_gpia2.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpia2
// Brief    : Directed self-checking bench for gpia2 (WIDTH=16, SYNC_STAGES=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_gpia2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [15:0] dat_i;
    logic [15:0] dat_o;
    logic        ack;
    logic [15:0] port_i;
    logic [15:0] port_o;
    logic [15:0] port_oe;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gpia2 #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .ADR_I     (adr),
        .WE_I      (we),
        .CYC_I     (cyc),
        .STB_I     (stb),
        .DAT_I     (dat_i),
        .DAT_O     (dat_o),
        .ACK_O     (ack),
        .PORT_I    (port_i),
        .PORT_O    (port_o),
        .PORT_OE_O (port_oe),
        .INT_O     (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = d;
        @(negedge clk);
        check("wr_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        check("rd_ack", {31'd0, ack}, 32'd1);
        d = dat_o;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
    endtask

    logic [15:0] rd;
    logic [15:0] exp_fall;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; adr = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        dat_i = '0; port_i = 16'hFFFF;
        idle(3);
        rst = 1'b0;
        idle(5);
        check("rst_port_o", {16'd0, port_o}, 32'h0000);
        check("rst_oe", {16'd0, port_oe}, 32'h0000);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_int", {31'd0, irq}, 32'd0);
        wb_read(3'd6, rd);
        check("rst_edge", {16'd0, rd}, 32'h0000);
        wb_read(3'd0, rd);
        check("rst_in", {16'd0, rd}, 32'hFFFF);

        // Set/clear/toggle sequence
        wb_write(3'd1, 16'h00F0);
        check("out_wr", {16'd0, port_o}, 32'h00F0);
        wb_write(3'd2, 16'h0F00);
        check("out_set", {16'd0, port_o}, 32'h0FF0);
        wb_write(3'd3, 16'h0010);
        check("out_clr", {16'd0, port_o}, 32'h0FE0);
        wb_write(3'd4, 16'h8001);
        check("out_tgl", {16'd0, port_o}, 32'h8FE1);
        wb_read(3'd2, rd);
        check("rd_set_adr", {16'd0, rd}, 32'h8FE1);
        wb_write(3'd5, 16'hA5A5);
        check("dir_oe", {16'd0, port_oe}, 32'hA5A5);
        wb_read(3'd5, rd);
        check("dir_rd", {16'd0, rd}, 32'hA5A5);
        wb_write(3'd0, 16'hFFFF);
        check("in_wr_ign_out", {16'd0, port_o}, 32'h8FE1);
        check("in_wr_ign_oe", {16'd0, port_oe}, 32'hA5A5);

        // Back-to-back: toggle held 4 cycles commits exactly twice
        wb_write(3'd1, 16'h0000);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd4; dat_i = 16'h0003;
        @(negedge clk);
        check("b2b_ack1", {31'd0, ack}, 32'd1);
        check("b2b_out1", {16'd0, port_o}, 32'h0003);
        @(negedge clk);
        check("b2b_ack2", {31'd0, ack}, 32'd0);
        check("b2b_out2", {16'd0, port_o}, 32'h0003);
        @(negedge clk);
        check("b2b_ack3", {31'd0, ack}, 32'd1);
        check("b2b_out3", {16'd0, port_o}, 32'h0000);
        @(negedge clk);
        check("b2b_ack4", {31'd0, ack}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("b2b_out_end", {16'd0, port_o}, 32'h0000);

        // STB dropped while ACK high
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd4; dat_i = 16'h0001;
        @(negedge clk);
        check("drop_ack1", {31'd0, ack}, 32'd1);
        stb = 1'b0;
        @(negedge clk);
        check("drop_ack2", {31'd0, ack}, 32'd0);
        @(negedge clk);
        check("drop_ack3", {31'd0, ack}, 32'd0);
        check("drop_out", {16'd0, port_o}, 32'h0001);
        cyc = 1'b0; we = 1'b0;

        // Edge latch and interrupt timing
        port_i = 16'h0000;
        idle(5);
        wb_write(3'd6, 16'hFFFF);
        wb_read(3'd6, rd);
        check("edge_clear", {16'd0, rd}, 32'h0000);
        wb_write(3'd7, 16'h0004);
        port_i = 16'h0005;
        idle(3);
        check("int_lat3", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("int_lat4", {31'd0, irq}, 32'd1);
        wb_read(3'd6, rd);
        check("edge_0005", {16'd0, rd}, 32'h0005);
        wb_read(3'd0, rd);
        check("in_0005", {16'd0, rd}, 32'h0005);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd6; dat_i = 16'h0004;
        @(negedge clk);
        check("w1c_int_hold", {31'd0, irq}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        check("w1c_int_fall", {31'd0, irq}, 32'd0);
        wb_read(3'd6, rd);
        check("edge_after_w1c", {16'd0, rd}, 32'h0001);

        // Set wins over simultaneous W1C
        port_i = 16'h0007;
        idle(5);
        wb_read(3'd6, rd);
        check("edge_bit1", {16'd0, rd}, 32'h0003);
        port_i = 16'h0005;
        idle(5);
        port_i = 16'h0007;
        @(negedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd6; dat_i = 16'h0002;
        @(negedge clk);
        check("race_ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        wb_read(3'd6, rd);
        check("race_set_wins", {16'd0, rd}, 32'h0003);
        wb_write(3'd6, 16'h0002);
        wb_read(3'd6, rd);
        check("w1c_bit1", {16'd0, rd}, 32'h0001);

        // Falling edge on bit 0
        port_i = 16'h0001;
        idle(5);
        wb_write(3'd6, 16'hFFFF);
        wb_read(3'd6, rd);
        check("edge_clear2", {16'd0, rd}, 32'h0000);
        port_i = 16'h0000;
        idle(5);
`ifdef GPIA2_ANY_EDGE_EN
        exp_fall = 16'h0001;
`else
        exp_fall = 16'h0000;
`endif
        wb_read(3'd6, rd);
        check("edge_fall", {16'd0, rd}, {16'd0, exp_fall});

        // Reset during a transfer abandons it
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 3'd1; dat_i = 16'h1234; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        check("rst_mid_out", {16'd0, port_o}, 32'h0000);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        idle(2);
        check("rst_mid_out2", {16'd0, port_o}, 32'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
